// File: rtl/hit_flash_scheduler.sv
// hit_flash_scheduler
// Light-gun hit detection by frame flashing. When a trigger pull is accepted,
// the scheduler draws one all-black frame and then one white frame per live
// target. The photodiode response in each frame decides a hit, a miss, or
// cheat rejection.
//
// Ports
//   clk              pixel clock, rising edge
//   screen_reset     asynchronous, active-high reset
//   frame_tick_i     one-clk pulse at vblank start
//   trigger_i        raw zapper trigger (asynchronous)
//   detect_i         raw zapper photodiode (asynchronous)
//   game_enable_i    high while the game is in play
//   target_active_i  per-target alive mask, latched when a shot is accepted
//   flash_black_o    draw an all-black frame
//   flash_sel_o      one-hot: draw only this target's hit box white
//   shot_fired_o     one-clk pulse when a shot is accepted
//   hit_o, hit_id_o  one-clk hit pulse; hit_id_o holds until the next hit
//   miss_o           one-clk pulse when a shot resolves without a hit
//   cheat_o          one-clk pulse when light is seen in the black frame
//   busy_o           high in every state except IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a trigger edge while the game is enabled
// WAIT_BLK | shot accepted, waiting for the next frame start
// BLACK    | all-black frame on screen, measuring stray light
// WHITE    | hit box of target cur on screen, measuring light
// HOLD     | shot resolved or aborted, waiting for trigger release
module hit_flash_scheduler #(
  parameter int N_TGT        = 4,
  parameter int DET_MIN      = 8,
  parameter bit CHEAT_REJECT = 1'b1
) (
  input  logic             clk,
  input  logic             screen_reset,
  input  logic             frame_tick_i,
  input  logic             trigger_i,
  input  logic             detect_i,
  input  logic             game_enable_i,
  input  logic [N_TGT-1:0] target_active_i,
  output logic             flash_black_o,
  output logic [N_TGT-1:0] flash_sel_o,
  output logic             shot_fired_o,
  output logic             hit_o,
  output logic [1:0]       hit_id_o,
  output logic             miss_o,
  output logic             cheat_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, WAIT_BLK, BLACK, WHITE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [1:0]       trig_sync_q, det_sync_q, fill_q;
  logic             trig_low_q;
  logic [15:0]      det_cnt_q, det_cnt_d;
  logic [N_TGT-1:0] snap_q, snap_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       hit_id_q, hit_id_d;
  logic             shot_q, shot_d, hit_q, hit_d, miss_q, miss_d, cheat_q, cheat_d;

  logic             trig_s, det_s, trig_rise, det_ok;
  logic [2:0]       lowest, nxt;
  logic [N_TGT-1:0] one_hot;

  assign trig_s = trig_sync_q[1];
  assign det_s  = det_sync_q[1];

  // The synchronizer output is only trusted as "released" once both stages
  // hold real samples, so a trigger held through reset never looks like a
  // fresh 0->1 edge.
  assign trig_rise = trig_s & trig_low_q;
  assign det_ok    = det_cnt_q >= 16'(DET_MIN);

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [2:0] find_set(input logic [N_TGT-1:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (i >= from && m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign lowest  = find_set(snap_q, 0);
  assign nxt     = find_set(snap_q, int'(cur_q) + 1);
  assign one_hot = {{(N_TGT-1){1'b0}}, 1'b1} << cur_q;

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      trig_sync_q <= 2'b00;
      det_sync_q  <= 2'b00;
      fill_q      <= 2'b00;
      trig_low_q  <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], trigger_i};
      det_sync_q  <= {det_sync_q[0], detect_i};
      fill_q      <= {fill_q[0], 1'b1};
      trig_low_q  <= fill_q[1] & ~trig_s;
    end
  end

  always_comb begin
    det_cnt_d = det_cnt_q;
    if (frame_tick_i)                     det_cnt_d = 16'd0;
    else if (det_s && det_cnt_q != 16'hFFFF) det_cnt_d = det_cnt_q + 16'd1;
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cur_d    = cur_q;
    hit_id_d = hit_id_q;
    shot_d   = 1'b0;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    cheat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (game_enable_i && trig_rise) begin
          shot_d  = 1'b1;
          snap_d  = target_active_i;
          state_d = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        if (!game_enable_i) state_d = HOLD;
        else if (snap_q == '0) begin
          // Nothing alive to flash: resolve as a miss without drawing anything.
          miss_d  = 1'b1;
          state_d = HOLD;
        end else if (frame_tick_i) state_d = BLACK;
      end
      BLACK: begin
        if (!game_enable_i) state_d = HOLD;
        else if (frame_tick_i) begin
          if (CHEAT_REJECT && det_ok) begin
            cheat_d = 1'b1;
            miss_d  = 1'b1;
            state_d = HOLD;
          end else begin
            cur_d   = lowest[1:0];
            state_d = WHITE;
          end
        end
      end
      WHITE: begin
        if (!game_enable_i) state_d = HOLD;
        else if (frame_tick_i) begin
          if (det_ok) begin
            hit_d    = 1'b1;
            hit_id_d = cur_q;
            state_d  = HOLD;
          end else if (nxt[2]) begin
            cur_d = nxt[1:0];
          end else begin
            miss_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!trig_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      state_q   <= IDLE;
      det_cnt_q <= 16'd0;
      snap_q    <= '0;
      cur_q     <= 2'd0;
      hit_id_q  <= 2'd0;
      shot_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      cheat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      det_cnt_q <= det_cnt_d;
      snap_q    <= snap_d;
      cur_q     <= cur_d;
      hit_id_q  <= hit_id_d;
      shot_q    <= shot_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      cheat_q   <= cheat_d;
    end
  end

  // Flash outputs decode straight from state, so they are mutually exclusive
  // and drop the instant reset asserts.
  assign flash_black_o = (state_q == BLACK);
  assign flash_sel_o   = (state_q == WHITE) ? one_hot : '0;
  assign busy_o        = (state_q != IDLE);
  assign shot_fired_o  = shot_q;
  assign hit_o         = hit_q;
  assign hit_id_o      = hit_id_q;
  assign miss_o        = miss_q;
  assign cheat_o       = cheat_q;

endmodule

// File: tb/tb_hit_flash_scheduler.sv
// Directed bench for hit_flash_scheduler (default parameters: N_TGT=4,
// DET_MIN=8, CHEAT_REJECT=1). Frames are FL clocks long; inputs change 1 ns
// after the rising edge and outputs are checked at that same point.
module tb_hit_flash_scheduler;
  localparam int FL = 20;

  logic       clk = 1'b0;
  logic       screen_reset, frame_tick, trigger, detect, game_enable;
  logic [3:0] target_active;
  logic       flash_black, shot_fired, hit, miss, cheat, busy;
  logic [3:0] flash_sel;
  logic [1:0] hit_id;

  int passed = 0;
  int total  = 0;

  int n_shot = 0, n_hit = 0, n_miss = 0, n_cheat = 0, n_black = 0, n_white = 0, n_bad = 0;
  logic [15:0] sel_hist = 16'h0;
  logic        prev_black = 1'b0;
  logic [3:0]  prev_sel = 4'h0;
  int b_shot, b_hit, b_miss, b_cheat, b_black, b_white;
  logic [15:0] b_hist;

  always #5 clk = ~clk;

  hit_flash_scheduler dut (
    .clk            (clk),
    .screen_reset   (screen_reset),
    .frame_tick_i   (frame_tick),
    .trigger_i      (trigger),
    .detect_i       (detect),
    .game_enable_i  (game_enable),
    .target_active_i(target_active),
    .flash_black_o  (flash_black),
    .flash_sel_o    (flash_sel),
    .shot_fired_o   (shot_fired),
    .hit_o          (hit),
    .hit_id_o       (hit_id),
    .miss_o         (miss),
    .cheat_o        (cheat),
    .busy_o         (busy)
  );

  // Event recorder: counts pulses, flash frames and illegal flash patterns.
  always @(negedge clk) begin
    if (shot_fired) n_shot++;
    if (hit) n_hit++;
    if (miss) n_miss++;
    if (cheat) n_cheat++;
    if (flash_black && !prev_black) n_black++;
    if (flash_sel != 4'h0 && flash_sel != prev_sel) begin
      n_white++;
      sel_hist = {sel_hist[11:0], flash_sel};
    end
    if (flash_black && flash_sel != 4'h0) n_bad++;
    if ((flash_sel & (flash_sel - 4'h1)) != 4'h0) n_bad++;
    prev_black = flash_black;
    prev_sel   = flash_sel;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_shot = n_shot; b_hit = n_hit; b_miss = n_miss; b_cheat = n_cheat;
    b_black = n_black; b_white = n_white; b_hist = sel_hist;
  endtask

  // Frame start pulse, then FL-1 cycles with detect high for k cycles mid-frame.
  task automatic frame(input int k);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 1; i < FL; i++) begin
      detect = (i >= 2 && i < 2 + k);
      step();
    end
    detect = 1'b0;
  endtask

  task automatic tick_only();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic fire(input string tag);
    trigger = 1'b1;
    step();
    step();
    chk({tag, "_shot_early"}, shot_fired, 1'b0);
    step();
    chk({tag, "_shot_edge3"}, shot_fired, 1'b1);
  endtask

  task automatic release_trig(input string tag);
    trigger = 1'b0;
    step();
    step();
    chk({tag, "_busy_hold"}, busy, 1'b1);
    step();
    chk({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    screen_reset = 1'b1; frame_tick = 1'b0; trigger = 1'b0; detect = 1'b0;
    game_enable = 1'b0; target_active = 4'h0;
    #1;
    chk("reset_outputs", {flash_black, flash_sel, shot_fired, hit, miss, cheat, busy, hit_id}, 0);
    repeat (3) step();
    screen_reset = 1'b0;
    repeat (4) step();
    chk("post_reset_idle", {flash_black, flash_sel, shot_fired, hit, miss, cheat, busy, hit_id}, 0);
    game_enable = 1'b1;

    // Mask 0101, light only in target 2's frame.
    target_active = 4'b0101;
    snap();
    fire("a");
    frame(0);
    chk("a_black_on", flash_black, 1'b1);
    frame(0);
    chk("a_sel_t0", flash_sel, 4'b0001);
    frame(10);
    chk("a_sel_t2", flash_sel, 4'b0100);
    tick_only();
    chk("a_hit", hit, 1'b1);
    chk("a_hit_id", hit_id, 2'd2);
    chk("a_no_miss", miss, 1'b0);
    step();
    chk("a_hit_one_clk", hit, 1'b0);
    chk("a_black_frames", n_black - b_black, 1);
    chk("a_white_frames", n_white - b_white, 2);
    chk("a_sel_order", sel_hist[7:0], 8'h14);
    chk("a_miss_count", n_miss - b_miss, 0);
    release_trig("a");

    // Mask 0011, no light at all.
    target_active = 4'b0011;
    snap();
    fire("b");
    frame(0);
    frame(0);
    frame(0);
    tick_only();
    chk("b_miss", miss, 1'b1);
    chk("b_no_hit", hit, 1'b0);
    chk("b_sel_order", sel_hist[7:0], 8'h12);
    chk("b_black_frames", n_black - b_black, 1);
    chk("b_hit_id_held", hit_id, 2'd2);
    step();
    chk("b_busy_while_held", busy, 1'b1);
    release_trig("b");

    // Light throughout the black frame.
    snap();
    fire("c");
    frame(15);
    tick_only();
    chk("c_cheat", cheat, 1'b1);
    chk("c_miss", miss, 1'b1);
    chk("c_no_hit", hit, 1'b0);
    chk("c_black_off", flash_black, 1'b0);
    chk("c_no_white", n_white - b_white, 0);
    chk("c_hist_same", sel_hist, b_hist);
    release_trig("c");

    // Empty mask.
    target_active = 4'b0000;
    snap();
    fire("d");
    chk("d_miss_not_yet", miss, 1'b0);
    step();
    chk("d_miss", miss, 1'b1);
    chk("d_shot_one_clk", shot_fired, 1'b0);
    step();
    chk("d_no_black", n_black - b_black, 0);
    chk("d_no_white", n_white - b_white, 0);
    release_trig("d");

    // Detect threshold on target 0: DET_MIN-1 misses, DET_MIN hits.
    target_active = 4'b0001;
    snap();
    fire("e1");
    frame(0);
    frame(7);
    tick_only();
    chk("e1_no_hit", hit, 1'b0);
    chk("e1_miss", miss, 1'b1);
    release_trig("e1");
    fire("e2");
    frame(0);
    frame(8);
    tick_only();
    chk("e2_hit", hit, 1'b1);
    chk("e2_hit_id", hit_id, 2'd0);
    chk("e2_no_miss", miss, 1'b0);
    release_trig("e2");

    // game_enable falls during the black frame.
    target_active = 4'b0011;
    snap();
    fire("f");
    frame(0);
    chk("f_black_on", flash_black, 1'b1);
    game_enable = 1'b0;
    step();
    chk("f_black_cleared", flash_black, 1'b0);
    chk("f_busy", busy, 1'b1);
    step();
    chk("f_no_pulse", (n_hit - b_hit) + (n_miss - b_miss), 0);
    game_enable = 1'b1;
    release_trig("f");

    // Reset during WHITE with the trigger held.
    snap();
    fire("g");
    frame(0);
    frame(0);
    chk("g_sel_t0", flash_sel, 4'b0001);
    screen_reset = 1'b1;
    #1;
    chk("g_reset_async", {flash_black, flash_sel, shot_fired, hit, miss, cheat, busy, hit_id}, 0);
    step();
    step();
    screen_reset = 1'b0;
    repeat (10) step();
    chk("g_no_refire", n_shot - b_shot, 1);
    chk("g_idle_held", busy, 1'b0);
    chk("g_no_pulse", (n_hit - b_hit) + (n_miss - b_miss) + (n_cheat - b_cheat), 0);
    trigger = 1'b0;
    repeat (3) step();
    fire("g2");
    game_enable = 1'b0;
    step();
    release_trig("g2");

    chk("flash_exclusive_onehot", n_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hit_flash_scheduler.md
HIT_FLASH_SCHEDULER -- requirements
Module: hit_flash_scheduler

Interface
REQ-001 SHALL have parameter N_TGT, default 4, number of targets sharing the flash frame (2..4).
REQ-002 SHALL have parameter DET_MIN, default 8, minimum synced-detect-high clk cycles in one frame that counts as "light seen".
REQ-003 SHALL have parameter CHEAT_REJECT, default 1; 1 = light seen in the black frame forces a miss.
REQ-004 clk  input  1  pixel clock; all state on rising edge.
REQ-005 screen_reset  input  1  reset, asynchronous, active-high.
REQ-006 frame_tick  input  1  one-clk pulse at start of each frame (vblank start).
REQ-007 trigger  input  1  raw zapper trigger, asynchronous.
REQ-008 detect  input  1  raw zapper photodiode, asynchronous.
REQ-009 game_enable  input  1  high while the game state is in play.
REQ-010 target_active  input  N_TGT  per-target "alive" mask, sampled at shot acceptance.
REQ-011 flash_black  output  1  pattern generator draws an all-black frame.
REQ-012 flash_sel  output  N_TGT  one-hot; draw only the selected target's hit box white, everything else black.
REQ-013 shot_fired  output  1  one-clk pulse on shot acceptance.
REQ-014 hit  output  1  one-clk pulse; hit_id is valid in the same cycle.
REQ-015 hit_id  output  2  index of the target that was hit.
REQ-016 miss  output  1  one-clk pulse when a shot resolves without a hit.
REQ-017 cheat  output  1  one-clk pulse when light is seen in the black frame; coincides with miss.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 trigger and detect SHALL each pass through a 2-flop synchronizer before use.
REQ-020 A shot SHALL be accepted only in IDLE with game_enable=1, on a synced-trigger 0->1 edge; shot_fired asserts on the 3rd rising edge at which raw trigger is sampled high.
REQ-021 On acceptance, target_active SHALL be latched into snap_mask and the FSM SHALL enter WAIT_BLK; if snap_mask==0, miss pulses instead and the FSM enters HOLD.
REQ-022 States SHALL be: IDLE, WAIT_BLK, BLACK, WHITE, HOLD.
REQ-023 WAIT_BLK -> BLACK on the next frame_tick; a frame_tick in the acceptance cycle itself does not count.
REQ-024 BLACK: flash_black=1 for exactly one frame; at the next frame_tick, if CHEAT_REJECT=1 and det_cnt>=DET_MIN, cheat and miss pulse -> HOLD; otherwise -> WHITE with cur = lowest set bit of snap_mask.
REQ-025 WHITE: flash_sel=onehot(cur) for one frame; at the next frame_tick, det_cnt>=DET_MIN gives hit with hit_id=cur -> HOLD; otherwise cur advances to the next higher set bit; if none remains, miss -> HOLD.
REQ-026 det_cnt SHALL count synced-detect-high cycles, be 16 bits wide, saturate at 0xFFFF, and clear on every frame_tick.
REQ-027 HOLD: all flash outputs are 0; the FSM returns to IDLE in the first cycle synced trigger==0. A held trigger can never re-fire.
REQ-028 game_enable falling in WAIT_BLK, BLACK or WHITE SHALL abort to HOLD next cycle with flash outputs cleared and no hit or miss pulse.
REQ-029 flash_black and flash_sel SHALL never be non-zero together; flash_sel SHALL be 0 or one-hot.
REQ-030 Per shot, exactly one of hit, miss or abort SHALL occur.
REQ-031 hit_id SHALL hold its last value between hit pulses.

Reset
REQ-032 screen_reset=1 SHALL immediately force IDLE, with all outputs, det_cnt, snap_mask, cur, hit_id and the synchronizers at 0.
REQ-033 Reset asserted mid-sequence SHALL produce no hit or miss pulse; after release, a trigger already held high SHALL NOT be accepted until it falls and rises again.

Verification
REQ-034 mask=4'b0101, trigger held, detect high only during target 2's white frame -> shot_fired; 1 black frame; white frames for targets 0 then 2; hit with hit_id=2; no miss.
REQ-035 mask=4'b0011, detect never high -> frames black, sel=0001, sel=0010, then miss; busy stays high until trigger released.
REQ-036 detect high throughout the black frame (CHEAT_REJECT=1) -> cheat and miss in the same cycle, no white frame issued.
REQ-037 mask=0 at trigger -> shot_fired, then miss next cycle, no flash outputs.
REQ-038 detect high for DET_MIN-1 cycles in target 0's frame -> no hit; for DET_MIN cycles -> hit, hit_id=0.
REQ-039 screen_reset pulse during WHITE with trigger held -> all outputs 0 at once; no pulse; no new shot until trigger goes low then high.
